// File: rtl/pipeline_hazard_controller_pkg.sv
package pipeline_hazard_controller_pkg;

  // RUN: normal decode; WAIT: fetch outstanding; WAIT_FLUSH: fetch outstanding with a flush owed
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT       = 2'd1,
    ST_WAIT_FLUSH = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_load,
  output logic                  if_id_load,
  output logic                  if_flush,
  output logic                  id_ex_bubble,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  hazard_state_t state, state_next;
  logic          load_use;
  logic          flush_req;

  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

  // WAIT and RUN share one decode once the fetch returns, so only a pending
  // flush distinguishes the states in the output logic.
  assign flush_req = (state == ST_WAIT_FLUSH) || branch_taken;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_RUN;
    if (!imem_ready) begin
      state_next = flush_req ? ST_WAIT_FLUSH : ST_WAIT;
    end
  end

  always_comb begin
    pc_load      = 1'b0;
    if_id_load   = 1'b0;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b1;
    if (!reset_n) begin
      pc_load = 1'b0;
    end else if (flush_req && imem_ready) begin
      pc_load  = 1'b1;
      if_flush = 1'b1;
    end else if (!imem_ready || load_use) begin
      pc_load = 1'b0;
    end else begin
      pc_load      = 1'b1;
      if_id_load   = 1'b1;
      id_ex_bubble = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (!pc_load && !if_flush),
    .count   (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (if_flush),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int unsigned AW     = 5;
  localparam int unsigned CW     = 4;
  localparam int          CNTMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
  logic          id_ex_mem_read = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
  logic          pc_load, if_id_load, if_flush, id_ex_bubble;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_controller #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .branch_taken   (branch_taken),
    .imem_ready     (imem_ready),
    .pc_load        (pc_load),
    .if_id_load     (if_id_load),
    .if_flush       (if_flush),
    .id_ex_bubble   (id_ex_bubble),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string         tag;
    logic [3:0]    ctl;   // {pc_load, if_id_load, if_flush, id_ex_bubble}
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: a flush owed to the front end, and the two event tallies.
  bit m_pending = 0;
  int m_sc = 0;
  int m_fc = 0;

  task automatic step(input string tag, input int rs1, input int rs2, input int rd,
                      input bit mr, input bit br, input bit rdy, input bit rst);
    exp_t e;
    bit   hazard, flush_now;
    @(posedge clock);
    #1;
    reset_n        = !rst;
    id_rs1         = AW'(rs1);
    id_rs2         = AW'(rs2);
    id_ex_rd       = AW'(rd);
    id_ex_mem_read = mr;
    branch_taken   = br;
    imem_ready     = rdy;
    e.tag = tag;
    if (rst) begin
      m_pending = 0;
      m_sc = 0;
      m_fc = 0;
      e.ctl = 4'b0001;
      e.sc  = '0;
      e.fc  = '0;
    end else begin
      hazard    = mr && (rd != 0) && (rd == rs1 || rd == rs2);
      flush_now = m_pending || br;
      if (flush_now && rdy) begin
        e.ctl = 4'b1011;
        m_pending = 0;
      end else if (!rdy) begin
        e.ctl = 4'b0001;
        m_pending = flush_now;
      end else if (hazard) begin
        e.ctl = 4'b0001;
      end else begin
        e.ctl = 4'b1100;
      end
      e.sc = CW'(m_sc);
      e.fc = CW'(m_fc);
      if (e.ctl == 4'b0001) m_sc = (m_sc < CNTMAX) ? m_sc + 1 : CNTMAX;
      if (e.ctl[1])         m_fc = (m_fc < CNTMAX) ? m_fc + 1 : CNTMAX;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 1, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clock) begin
    exp_t e;
    logic [3:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_load, if_id_load, if_flush, id_ex_bubble};
      n_checks++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b (t=%0t)", e.tag, act, e.ctl, $time);
      end
      n_checks++;
      if (stall_count !== e.sc || flush_count !== e.fc) begin
        n_fail++;
        $display("FAIL %s counts: got stall=%0d flush=%0d expected stall=%0d flush=%0d (t=%0t)",
                 e.tag, stall_count, flush_count, e.sc, e.fc, $time);
      end
    end
  end

  initial begin
    // reset state, inputs deliberately noisy
    step("reset", 1, 1, 1, 1, 1, 0, 1);
    step("reset_hold", 3, 2, 3, 1, 1, 1, 1);
    idle("run_after_reset", 2);

    // load-use on rs2
    step("load_use", 0, 5, 5, 1, 0, 1, 0);
    idle("after_load_use", 1);

    // x0 exemption
    step("x0_exempt", 0, 7, 0, 1, 0, 1, 0);

    // branch hidden by a 3-cycle fetch wait
    step("rst_pre_wait", 0, 0, 0, 0, 0, 1, 1);
    step("br_wait1", 0, 0, 0, 0, 1, 0, 0);
    step("br_wait2", 0, 0, 0, 0, 0, 0, 0);
    step("br_wait3", 0, 0, 0, 0, 1, 0, 0);
    step("br_release", 0, 0, 0, 0, 0, 1, 0);
    idle("after_br_wait", 2);

    // branch and load-use together
    step("br_and_load_use", 4, 0, 4, 1, 1, 1, 0);
    idle("after_br_lu", 1);

    // WAIT then branch while waiting, then plain WAIT release
    step("wait_plain", 0, 0, 0, 0, 0, 0, 0);
    step("wait_then_br", 0, 0, 0, 0, 1, 0, 0);
    step("wait_flush_rel", 0, 0, 0, 0, 0, 1, 0);
    step("wait_only", 0, 0, 0, 0, 0, 0, 0);
    step("wait_rel_lu", 2, 0, 2, 1, 0, 1, 0);

    // stall counter saturation
    for (int i = 0; i < 20; i++) step("saturate", 0, 0, 0, 0, 0, 0, 0);
    idle("saturated_hold", 1);

    // reset in WAIT_FLUSH discards the pending flush
    step("rst_pre_wf", 0, 0, 0, 0, 0, 1, 1);
    step("enter_wf", 0, 0, 0, 0, 1, 0, 0);
    step("reset_in_wf", 0, 0, 0, 0, 0, 1, 1);
    step("no_flush_after_rst", 0, 0, 0, 0, 0, 1, 0);
    idle("after_wf_rst", 1);

    // randomized traffic with small register indices so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      step("random",
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end

    @(posedge clock);
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width.
REQ-002 Parameter: CNT_W, default 16, width of each event counter.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the instruction in ID.
REQ-006 Port: id_ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
REQ-007 Port: id_ex_mem_read  in  1  the instruction in EX is a load.
REQ-008 Port: branch_taken  in  1  single-cycle pulse from EX meaning the branch or jump resolved taken.
REQ-009 Port: imem_ready  in  1  instruction memory returns a valid word this cycle.
REQ-010 Port: pc_load  out  1  PC write enable.
REQ-011 Port: if_id_load  out  1  drives the IF/ID register load input.
REQ-012 Port: if_flush  out  1  drives the IF/ID register if_flush input.
REQ-013 Port: id_ex_bubble  out  1  zeroes the ID/EX control fields.
REQ-014 Port: stall_count, flush_count  out  CNT_W each  event counters.

Function
REQ-015 The four control outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-016 load_use SHALL be 1 iff id_ex_mem_read=1 and id_ex_rd!=0 and (id_ex_rd==id_rs1 or id_ex_rd==id_rs2).
REQ-017 The FSM SHALL have exactly three states: RUN, WAIT (instruction fetch outstanding) and WAIT_FLUSH (fetch outstanding, flush pending).
REQ-018 Decode priority SHALL be, highest first: pending or current flush, then imem wait, then load-use, then normal.
REQ-019 In RUN with branch_taken=1 and imem_ready=1, the block SHALL drive if_flush=1, id_ex_bubble=1, pc_load=1 and if_id_load=0, and SHALL stay in RUN.
REQ-020 In RUN with branch_taken=1 and imem_ready=0, the block SHALL drive pc_load=0, if_id_load=0, if_flush=0 and id_ex_bubble=1, and SHALL go to WAIT_FLUSH.
REQ-021 In RUN with branch_taken=0 and imem_ready=0, the block SHALL drive pc_load=0, if_id_load=0 and id_ex_bubble=1, and SHALL go to WAIT.
REQ-022 In RUN with imem_ready=1, branch_taken=0 and load_use=1, the block SHALL drive pc_load=0, if_id_load=0 and id_ex_bubble=1.
REQ-023 In RUN with imem_ready=1, branch_taken=0 and load_use=0, the block SHALL drive pc_load=1, if_id_load=1, if_flush=0 and id_ex_bubble=0.
REQ-024 In WAIT, imem_ready=0 SHALL hold the stall outputs of REQ-021, and a branch_taken=1 in that cycle SHALL move the FSM to WAIT_FLUSH.
REQ-025 In WAIT, imem_ready=1 SHALL return the FSM to RUN and apply the RUN decode in that same cycle.
REQ-026 In WAIT_FLUSH, imem_ready=0 SHALL hold the stall outputs.
REQ-027 In WAIT_FLUSH, imem_ready=1 SHALL produce the REQ-019 outputs and return the FSM to RUN.
REQ-028 Further branch_taken pulses in WAIT_FLUSH SHALL merge into the single pending flush.
REQ-029 stall_count SHALL increment by 1 on every cycle with pc_load=0 and if_flush=0.
REQ-030 flush_count SHALL increment by 1 on every cycle with if_flush=1.
REQ-031 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately force state to RUN and both counters to 0.
REQ-033 While reset_n=0, the block SHALL drive pc_load=0, if_id_load=0, if_flush=0 and id_ex_bubble=1, regardless of the other inputs.
REQ-034 Reset asserted in WAIT_FLUSH SHALL discard the pending flush.
REQ-035 The first rising clock edge after reset_n deasserts SHALL evaluate in RUN.

Structure
REQ-036 The FSM state encoding type and the state constants SHALL live in the shared pipeline package.
REQ-037 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.
REQ-038 The hazard comparison (load_use) SHALL stay inline in this block.

Verification
REQ-039 Load-use: id_ex_mem_read=1, id_ex_rd=5, id_rs2=5, imem_ready=1 -> pc_load=0, if_id_load=0, id_ex_bubble=1 for 1 cycle; stall_count=1.
REQ-040 x0 exemption: id_ex_mem_read=1, id_ex_rd=0, id_rs1=0 -> pc_load=1, if_id_load=1, id_ex_bubble=0.
REQ-041 Branch hidden by a wait: branch_taken pulse with imem_ready=0 for 3 cycles, then 1 -> stall on 3 cycles, then if_flush=1 exactly once; flush_count=1, stall_count=3.
REQ-042 Simultaneous events: branch_taken=1 and load_use=1 with imem_ready=1 -> if_flush=1, pc_load=1, no stall counted.
REQ-043 Saturation: CNT_W=4, 20 stall cycles -> stall_count holds at 15.
REQ-044 Asynchronous reset in WAIT_FLUSH: reset_n pulse low mid-cycle -> outputs go to reset values immediately; after release with imem_ready=1, no if_flush is issued.
